instr_fetch_unit: RTL

- Instruction-side consumer of the PC stream. It accepts a PC from the PC generator and issues a single-outstanding read to instruction memory.
- Returned instruction words are buffered in a small FIFO and presented to decode with a valid/ready handshake, each tagged with its PC.
- A flush (taken branch or reset vector change) discards buffered and in-flight fetches so decode never sees wrong-path instructions.

---
 rtl/instr_fetch_unit_if.sv | 36 +++
 rtl/instr_fetch_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the instruction fetch unit and its environment:
// PC generator handshake, flush, instruction memory port and decode handshake.
// The slave modport is the fetch unit itself; the master modport is whatever
// surrounds it (PC generator, memory, decode).
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] pc_in;
  logic              pc_valid;
  logic              pc_ready;
  logic              flush;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_misaligned;
  logic              busy;

  modport slave (
    input  pc_in, pc_valid, flush, mem_gnt, mem_rvalid, mem_rdata, instr_ready,
    output pc_ready, mem_req, mem_addr, instr_valid, instr, instr_pc,
           instr_misaligned, busy
  );

  modport master (
    output pc_in, pc_valid, flush, mem_gnt, mem_rvalid, mem_rdata, instr_ready,
    input  pc_ready, mem_req, mem_addr, instr_valid, instr, instr_pc,
           instr_misaligned, busy
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: accepts PCs, issues one outstanding memory read at a
// time, buffers returned words (tagged with their PC) in a small FIFO for
// decode, and discards everything buffered or in flight on flush.
module instr_fetch_unit #(
  parameter int              ADDR_W     = 32,
  parameter int              DATA_W     = 32,
  parameter int              FIFO_DEPTH = 2,
  parameter logic [DATA_W-1:0] NOP_INSTR = 32'h00000013
) (
  input logic               sysclk,
  input logic               reset_n,
  instr_fetch_unit_if.slave bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;

  // FIFO storage and bookkeeping
  logic [DATA_W-1:0] fifo_data_reg [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_pc_reg   [FIFO_DEPTH];
  logic              fifo_mis_reg  [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;

  logic              push;
  logic [DATA_W-1:0] push_data;
  logic [ADDR_W-1:0] push_pc;
  logic              push_mis;
  logic              pop;
  logic              fifo_empty;
  logic              accept;
  logic              pc_aligned;

  assign fifo_empty   = (count_reg == '0);
  // A free slot at acceptance time is what guarantees the response a place.
  assign bus.pc_ready = (state_reg == S_IDLE) && (count_reg < CNT_W'(FIFO_DEPTH)) && !bus.flush;
  assign accept       = bus.pc_valid && bus.pc_ready;
  assign pc_aligned   = (bus.pc_in[1:0] == 2'b00);
  assign pop          = !fifo_empty && bus.instr_ready;

  // State and latched-PC register
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
      pc_reg    <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  // Next-state logic and FIFO push selection
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    push       = 1'b0;
    push_data  = '0;
    push_pc    = '0;
    push_mis   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          if (pc_aligned) begin
            pc_next    = bus.pc_in;
            state_next = S_REQ;
          end else begin
            // Misaligned: no memory access, hand decode a NOP tagged with the PC
            push      = 1'b1;
            push_data = NOP_INSTR;
            push_pc   = bus.pc_in;
            push_mis  = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (bus.mem_gnt) begin
          // Granted in the flush cycle: the response still arrives and must be eaten
          state_next = bus.flush ? S_DROP : S_WAIT;
        end else if (bus.flush) begin
          state_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (bus.mem_rvalid) begin
          state_next = S_IDLE;
          if (!bus.flush) begin
            push      = 1'b1;
            push_data = bus.mem_rdata;
            push_pc   = pc_reg;
          end
        end else if (bus.flush) begin
          state_next = S_DROP;
        end
      end
      S_DROP: begin
        if (bus.mem_rvalid) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // One register slot per FIFO entry, written when the write pointer selects it
  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
          fifo_data_reg[gi] <= '0;
          fifo_pc_reg[gi]   <= '0;
          fifo_mis_reg[gi]  <= 1'b0;
        end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
          fifo_data_reg[gi] <= push_data;
          fifo_pc_reg[gi]   <= push_pc;
          fifo_mis_reg[gi]  <= push_mis;
        end
      end
    end
  endgenerate

  // FIFO pointers and occupancy; flush empties the buffer outright
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (bus.flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Head of the FIFO drives decode; fields read as zero while empty
  assign bus.instr_valid      = !fifo_empty;
  assign bus.instr            = fifo_empty ? '0   : fifo_data_reg[rd_ptr_reg];
  assign bus.instr_pc         = fifo_empty ? '0   : fifo_pc_reg[rd_ptr_reg];
  assign bus.instr_misaligned = fifo_empty ? 1'b0 : fifo_mis_reg[rd_ptr_reg];

  assign bus.mem_req  = (state_reg == S_REQ);
  assign bus.mem_addr = pc_reg;
  assign bus.busy     = (state_reg != S_IDLE) || !fifo_empty;

endmodule
